// File: rtl/fpmult_arbiter.sv
// Round-robin sequencer sharing one iterative multiplier among NREQ val/rdy requesters.
// One transaction in flight; the result is routed back to the requester that issued it.
module fpmult_arbiter #(
  parameter int unsigned n    = 32,
  parameter int unsigned d    = 16,
  parameter int unsigned NREQ = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NREQ-1:0]              req_recv_val,
  output logic [NREQ-1:0]              req_recv_rdy,
  input  logic [NREQ*n-1:0]            req_a,
  input  logic [NREQ*n-1:0]            req_b,
  output logic [NREQ-1:0]              req_send_val,
  input  logic [NREQ-1:0]              req_send_rdy,
  output logic [n-1:0]                 req_c,
  output logic                         mult_recv_val,
  input  logic                         mult_recv_rdy,
  output logic [n-1:0]                 mult_a,
  output logic [n-1:0]                 mult_b,
  input  logic                         mult_send_val,
  output logic                         mult_send_rdy,
  input  logic [n-1:0]                 mult_c,
  output logic [$clog2(NREQ)-1:0]      grant_id,
  output logic                         busy
);

  localparam int unsigned IdW = $clog2(NREQ);

  if (NREQ < 2) begin : g_nreq_check
    $error("fpmult_arbiter needs at least two requesters");
  end
  if (d >= n) begin : g_frac_check
    $error("fractional width must be smaller than the data width");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e         state_q, state_d;
  logic [IdW-1:0] ptr_q, ptr_d;
  logic [IdW-1:0] grant_q, grant_d;
  logic [n-1:0]   a_q, a_d;
  logic [n-1:0]   b_q, b_d;
  logic [n-1:0]   c_q, c_d;

  logic           found;
  logic [IdW-1:0] sel;
  int unsigned    idx;

  // Rotating priority search starting at ptr; wrap by subtraction so any NREQ works.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_recv_val[idx[IdW-1:0]]) begin
        found = 1'b1;
        sel   = idx[IdW-1:0];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    a_d           = a_q;
    b_d           = b_q;
    c_d           = c_q;
    req_recv_rdy  = '0;
    req_send_val  = '0;
    mult_recv_val = 1'b0;
    mult_send_rdy = 1'b0;
    case (state_q)
      StIdle: begin
        // Gate with reset so no ready leaks out while the block is held in reset.
        if (found && !reset) begin
          req_recv_rdy[sel] = 1'b1;
          a_d               = req_a[32'(sel) * n +: n];
          b_d               = req_b[32'(sel) * n +: n];
          grant_d           = sel;
          state_d           = StIssue;
        end
      end
      StIssue: begin
        mult_recv_val = 1'b1;
        if (mult_recv_rdy) state_d = StWait;
      end
      StWait: begin
        mult_send_rdy = 1'b1;
        if (mult_send_val) begin
          c_d     = mult_c;
          state_d = StResp;
        end
      end
      StResp: begin
        req_send_val[grant_q] = 1'b1;
        if (req_send_rdy[grant_q]) begin
          ptr_d   = (grant_q == IdW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      grant_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
    end
  end

  assign grant_id = grant_q;
  assign busy     = (state_q != StIdle);
  assign mult_a   = a_q;
  assign mult_b   = b_q;
  assign req_c    = c_q;

endmodule

// File: doc/fpmult_arbiter.md
Name: fpmult_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one iterative fixed-point multiplier among NREQ requesters.
- Each requester has a val/rdy request channel (a, b) and a val/rdy response channel (c).
- Sits between client blocks and a single multiplier instance. Drives the multiplier's recv/send handshakes and routes each result back to the requester that issued it.
- At most one transaction is in flight.

Parameters:
- n, 32, operand/result bit width (passed through to the multiplier)
- d, 16, fractional bits (informational; not used in arbitration logic)
- NREQ, 4, number of requesters (≥2)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- req_recv_val  in  NREQ  per-requester request valid
- req_recv_rdy  out  NREQ  per-requester request ready
- req_a  in  NREQ*n  flattened operand a; requester i owns bits [i*n +: n]
- req_b  in  NREQ*n  flattened operand b, same packing as req_a
- req_send_val  out  NREQ  per-requester response valid
- req_send_rdy  in  NREQ  per-requester response ready
- req_c  out  n  result, shared by all requesters; qualified by req_send_val
- mult_recv_val  out  1  request valid to the multiplier
- mult_recv_rdy  in  1  multiplier ready
- mult_a  out  n  operand a to the multiplier
- mult_b  out  n  operand b to the multiplier
- mult_send_val  in  1  multiplier result valid
- mult_send_rdy  out  1  ready for the multiplier result
- mult_c  in  n  multiplier result
- grant_id  out  $clog2(NREQ)  index of the requester currently owning the multiplier
- busy  out  1  high in any state other than IDLE

Behaviour:
- State machine: IDLE, ISSUE, WAIT, RESP. 2-bit state register.
- Asynchronous reset clears the following:
  - state goes to IDLE
  - priority pointer ptr goes to 0
  - grant_id goes to 0
  - operand and result registers go to 0
- All outputs are 0 while reset is asserted, including req_recv_rdy.
- IDLE:
  - Select the first i with req_recv_val[i]=1, searching ptr, ptr+1, …, wrapping mod NREQ.
  - Assert req_recv_rdy[i] combinationally for that i only; all other rdy bits are 0.
  - No valid requester: all rdy bits are 0 and state stays IDLE.
  - On a handshake, latch req_a[i] and req_b[i] into operand registers, set grant_id=i, and go to ISSUE.
- ISSUE:
  - mult_recv_val=1; mult_a/mult_b are driven from the operand registers, stable until accepted.
  - When mult_recv_rdy=1, go to WAIT.
- WAIT:
  - mult_send_rdy=1.
  - When mult_send_val=1, latch mult_c into the result register and go to RESP.
- RESP:
  - req_send_val[grant_id]=1; all other send_val bits are 0.
  - req_c is the result register, stable while waiting.
  - When req_send_rdy[grant_id]=1: ptr ← (grant_id+1) mod NREQ, go to IDLE.
  - req_send_rdy of non-granted requesters is ignored.
- mult_a/mult_b equal the operand registers in all states. mult_recv_val is 0 outside ISSUE; mult_send_rdy is 0 outside WAIT.
- Simultaneous requests: exactly one grant per transaction. ptr advances only after a response completes, so every valid requester is served within NREQ transactions.
- req_recv_val toggling while not granted: no effect; requesters hold their request until they see rdy.
- A requester may re-request in the cycle after its own response. It loses to any other valid requester because ptr has moved past it.
- Latency, from the request handshake to the first req_send_val cycle: 1 (ISSUE) + multiplier compute cycles + 1 (RESP entry).
- A new request is accepted no earlier than the cycle after the response handshake.
- Reset mid-transaction (any state):
  - Immediate return to IDLE with ptr=0.
  - The in-flight result is discarded and no req_send_val pulse is produced.
  - The multiplier shares the same reset and aborts in step.
- Widths: no arithmetic on data; operands and result pass through unmodified. ptr wrap is a compare-to-(NREQ-1), so non-power-of-two NREQ is supported.

Test Plan:
- Single request, n=32, d=16, requester 2 sends a=0x00018000, b=0x00020000 (1.5×2.0) -> req_send_val[2] pulses with req_c=0x00030000; grant_id=2; other send_val bits stay 0.
- Signed operands, requester 0 sends a=0xFFFF0000, b=0x00008000 (−1.0×0.5) -> req_c=0xFFFF8000.
- All four requesters hold val=1 continuously with distinct operands -> grants occur in order 0,1,2,3,0; each receives its own correct product.
- Response backpressure: hold req_send_rdy[1]=0 for 5 cycles in RESP -> req_c and req_send_val[1] stay stable; all req_recv_rdy bits stay 0 until the handshake.
- Assert reset during WAIT -> next cycle state=IDLE, busy=0, and no req_send_val is raised. A subsequent request from requester 3 with a=b=0x00010000 returns 0x00010000 and is granted with ptr starting at 0.
- Stall the multiplier by holding mult_recv_rdy=0 for 3 cycles in ISSUE (stubbed multiplier) -> mult_recv_val stays 1 and mult_a/mult_b stay unchanged.
